// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes used by the acceptor and the vending FSM,
// plus the acceptor state encoding.
package vend_pkg;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_NONE = 2'b00;
   localparam coin_t COIN_1    = 2'b01;
   localparam coin_t COIN_2    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_GAP     = 2'd2,
      ST_JAM     = 2'd3
   } acc_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bundle: sensor/enable towards the acceptor, code and status back.
interface coin_acceptor_if;
   import vend_pkg::*;

   logic  coin_sense;
   logic  enable;
   coin_t coin;
   logic  reject;
   logic  jam;
   logic  busy;

   modport master (
      output coin_sense, enable,
      input  coin, reject, jam, busy
   );

   modport slave (
      input  coin_sense, enable,
      output coin, reject, jam, busy
   );

endinterface

// File: rtl/sense_sync.sv
// Two-flop synchroniser for the asynchronous coin-slot sensor.
module sense_sync (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic s
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         s    <= 1'b0;
      end else begin
         meta <= raw;
         s    <= meta;
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Classifies coins by sensor pulse length; emits one-cycle coin codes, reject pulses
// and a jam level, with a refractory gap after every coin, jam or reset.
module coin_acceptor
   import vend_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int MIN1    = 4,
   parameter int MAX1    = 9,
   parameter int MIN2    = 10,
   parameter int MAX2    = 20,
   parameter int JAM_LEN = 200,
   parameter int GAP     = 8
) (
   input logic           clk,
   input logic           rst,
   coin_acceptor_if.slave bus
);

   localparam logic [CNT_W-1:0] MIN1_C = CNT_W'(MIN1);
   localparam logic [CNT_W-1:0] MAX1_C = CNT_W'(MAX1);
   localparam logic [CNT_W-1:0] MIN2_C = CNT_W'(MIN2);
   localparam logic [CNT_W-1:0] MAX2_C = CNT_W'(MAX2);
   localparam logic [CNT_W-1:0] JAM_C  = CNT_W'(JAM_LEN);
   localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP);

   function automatic logic in_window(input logic [CNT_W-1:0] len,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (len >= lo) && (len <= hi);
   endfunction

   logic             s;
   acc_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] gap_cnt;
   coin_t            coin_code;
   logic             reject_pulse;
   logic             jam_level;
   logic             busy_flag;

   sense_sync u_sync (
      .clk (clk),
      .rst (rst),
      .raw (bus.coin_sense),
      .s   (s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_GAP;
         gap_cnt      <= GAP_C;
         cnt          <= '0;
         coin_code    <= COIN_NONE;
         reject_pulse <= 1'b0;
         jam_level    <= 1'b0;
         busy_flag    <= 1'b1;
      end else begin
         coin_code    <= COIN_NONE;
         reject_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (s) begin
                  state     <= ST_MEASURE;
                  cnt       <= CNT_W'(1);
                  busy_flag <= 1'b1;
               end
            end
            ST_MEASURE: begin
               if (!s) begin
                  // Classify on the falling edge; enable is only sampled here.
                  state   <= ST_GAP;
                  gap_cnt <= GAP_C;
                  if (!bus.enable)
                     reject_pulse <= 1'b1;
                  else if (in_window(cnt, MIN1_C, MAX1_C))
                     coin_code <= COIN_1;
                  else if (in_window(cnt, MIN2_C, MAX2_C))
                     coin_code <= COIN_2;
                  else
                     reject_pulse <= 1'b1;
               end else if (cnt == JAM_C) begin
                  state     <= ST_JAM;
                  jam_level <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_JAM: begin
               if (!s) begin
                  state     <= ST_GAP;
                  gap_cnt   <= GAP_C;
                  jam_level <= 1'b0;
               end
            end
            ST_GAP: begin
               // A sensor still high after the count expires is a partial pulse; wait it out.
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end else if (!s) begin
                  state     <= ST_IDLE;
                  busy_flag <= 1'b0;
               end
            end
            default: begin
               state     <= ST_GAP;
               gap_cnt   <= GAP_C;
               jam_level <= 1'b0;
               busy_flag <= 1'b1;
            end
         endcase
      end
   end

   assign bus.coin   = coin_code;
   assign bus.reject = reject_pulse;
   assign bus.jam    = jam_level;
   assign bus.busy   = busy_flag;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed boundary, jam, drop and reset scenarios plus
// randomized pulses checked against a length/enable classification model.
module tb_coin_acceptor;
   import vend_pkg::*;

   localparam int CNT_W   = 8;
   localparam int MIN1    = 4;
   localparam int MAX1    = 9;
   localparam int MIN2    = 10;
   localparam int MAX2    = 20;
   localparam int JAM_LEN = 200;
   localparam int GAP     = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   coin_acceptor_if bus ();

   coin_acceptor #(
      .CNT_W(CNT_W), .MIN1(MIN1), .MAX1(MAX1), .MIN2(MIN2),
      .MAX2(MAX2), .JAM_LEN(JAM_LEN), .GAP(GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Expected {reject, coin} for a pulse of raw length len seen with enable en.
   function automatic logic [2:0] ref_result(input int len, input bit en);
      if (!en)                          return {1'b1, COIN_NONE};
      if (len >= MIN1 && len <= MAX1)   return {1'b0, COIN_1};
      if (len >= MIN2 && len <= MAX2)   return {1'b0, COIN_2};
      return {1'b1, COIN_NONE};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input coin_t c, input logic r);
      chk({tag, "_coin"}, 32'(bus.coin), 32'(c));
      chk({tag, "_reject"}, 32'(bus.reject), 32'(r));
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100 && bus.busy !== 1'b0; i++) @(negedge clk);
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   // Drive one pulse of len raw samples; enable wanders during the pulse and is
   // set to en for the classify cycle. Expect the result 3 edges after release.
   task automatic run_pulse(input string tag, input int len, input bit en);
      logic [2:0] exp;
      exp = ref_result(len, en);
      bus.coin_sense = 1'b1;
      for (int i = 0; i < len; i++) begin
         bus.enable = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk_out({tag, "_high"}, COIN_NONE, 1'b0);
      end
      bus.coin_sense = 1'b0;
      bus.enable     = en;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 3) chk_out(tag, exp[1:0], exp[2]);
         else        chk_out({tag, "_quiet"}, COIN_NONE, 1'b0);
      end
   endtask

   initial begin
      int len;
      bit en;

      rst            = 1'b1;
      bus.coin_sense = 1'b0;
      bus.enable     = 1'b0;
      repeat (3) @(negedge clk);
      chk_out("reset", COIN_NONE, 1'b0);
      chk("reset_jam", 32'(bus.jam), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_busy", 32'(bus.busy), 32'd1);
      wait_idle("startup");

      // Nominal coins and window boundaries
      run_pulse("p6", 6, 1'b1);     wait_idle("p6");
      run_pulse("p15", 15, 1'b1);   wait_idle("p15");
      run_pulse("b3", 3, 1'b1);     wait_idle("b3");
      run_pulse("b4", 4, 1'b1);     wait_idle("b4");
      run_pulse("b9", 9, 1'b1);     wait_idle("b9");
      run_pulse("b10", 10, 1'b1);   wait_idle("b10");
      run_pulse("b20", 20, 1'b1);   wait_idle("b20");
      run_pulse("b21", 21, 1'b1);   wait_idle("b21");
      run_pulse("dis6", 6, 1'b0);   wait_idle("dis6");

      // Randomized pulses
      for (int n = 0; n < 24; n++) begin
         len = int'($urandom_range(1, 26));
         en  = 1'($urandom_range(0, 3) != 0);
         run_pulse($sformatf("rnd%0d_len%0d_en%0d", n, len, en), len, en);
         wait_idle("rnd");
      end

      // Jam: sensor held high for 250 samples
      bus.enable     = 1'b1;
      bus.coin_sense = 1'b1;
      for (int e = 0; e < 250; e++) begin
         @(negedge clk);
         if (e == 201 || e == 202 || e == 249)
            chk($sformatf("jam_e%0d", e), 32'(bus.jam), 32'(e >= 202));
         chk_out("jam_hold", COIN_NONE, 1'b0);
      end
      bus.coin_sense = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k <= 4) chk($sformatf("jam_rel_k%0d", k), 32'(bus.jam), 32'(k < 3));
         chk_out("jam_release", COIN_NONE, 1'b0);
      end
      wait_idle("jam");
      run_pulse("after_jam", 6, 1'b1);

      // Pulse arriving during the refractory gap is dropped
      wait_idle("pre_drop");
      bus.coin_sense = 1'b1;
      repeat (6) @(negedge clk);
      bus.coin_sense = 1'b0;
      repeat (3) @(negedge clk);
      chk_out("drop_first", COIN_1, 1'b0);
      repeat (3) @(negedge clk);
      bus.coin_sense = 1'b1;
      repeat (6) @(negedge clk);
      bus.coin_sense = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk_out("drop_second", COIN_NONE, 1'b0);
      end
      wait_idle("drop");

      // Reset in the middle of a 15-sample pulse
      bus.coin_sense = 1'b1;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_out("midrst", COIN_NONE, 1'b0);
      chk("midrst_jam", 32'(bus.jam), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk_out("midrst_tail", COIN_NONE, 1'b0);
      end
      bus.coin_sense = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk_out("midrst_after", COIN_NONE, 1'b0);
      end
      wait_idle("midrst");
      run_pulse("after_rst", 6, 1'b1);
      wait_idle("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
